// File: rtl/sa_gemm_sequencer.sv
// Tile-command sequencer feeding an N x N systolic array: weight load, input/partial-sum
// streaming, outstanding-GEMM tracking against the output FIFO, and sticky error capture.
module sa_gemm_sequencer #(
   parameter int unsigned N               = 32,
   parameter int unsigned DW              = 16,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned TIMEOUT         = 2000
) (
   input  logic                                 clk,
   input  logic                                 nRST,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic                                 cmd_reuse_w,
   input  logic                                 src_valid,
   output logic                                 src_ready,
   input  logic [DW*N-1:0]                      src_data,
   input  logic [DW*N-1:0]                      src_ps,
   output logic                                 weight_en,
   output logic                                 input_en,
   output logic                                 partial_en,
   output logic [$clog2(N)-1:0]                 row_in_en,
   output logic [$clog2(N)-1:0]                 row_ps_en,
   output logic [DW*N-1:0]                      array_in,
   output logic [DW*N-1:0]                      array_in_partials,
   input  logic                                 fifo_has_space,
   input  logic                                 drained,
   input  logic                                 out_en,
   input  logic [$clog2(N)-1:0]                 row_out,
   input  logic [DW*N-1:0]                      array_output,
   output logic                                 res_valid,
   output logic [$clog2(N)-1:0]                 res_row,
   output logic [DW*N-1:0]                      res_data,
   output logic                                 res_last,
   output logic                                 idle,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
   output logic                                 timeout_err,
   output logic                                 protocol_err,
   input  logic                                 err_clr
);

   localparam int unsigned RW = $clog2(N);
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
   localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);
   localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD_W     = 2'd1,
      WAIT_SPACE = 2'd2,
      STREAM     = 2'd3
   } state_t;

   state_t        state, state_next;
   logic [RW-1:0] beat_cnt, beat_cnt_next;
   logic          w_resident, w_resident_next;
   logic          w_beat, s_beat, inc, gap;
   logic          dec_req, dec_ok, underflow;
   logic [TW-1:0] tcnt, tcnt_next;
   logic          t_set, p_set;

   // State, beat counter and weight-residency registers
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         beat_cnt   <= '0;
         w_resident <= 1'b0;
      end else begin
         state      <= state_next;
         beat_cnt   <= beat_cnt_next;
         w_resident <= w_resident_next;
      end
   end

   // Next-state, handshakes and beat qualification
   always_comb begin
      state_next      = state;
      beat_cnt_next   = beat_cnt;
      w_resident_next = w_resident;
      cmd_ready       = 1'b0;
      src_ready       = 1'b0;
      w_beat          = 1'b0;
      s_beat          = 1'b0;
      inc             = 1'b0;
      gap             = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = (outstanding < OUT_MAX);
            if (cmd_valid && cmd_ready) begin
               if (cmd_reuse_w && w_resident) begin
                  state_next = WAIT_SPACE;
               end else begin
                  state_next      = LOAD_W;
                  w_resident_next = 1'b0;
               end
            end
         end
         LOAD_W: begin
            src_ready = 1'b1;
            if (src_valid) begin
               w_beat = 1'b1;
               if (beat_cnt == LAST_ROW) begin
                  beat_cnt_next   = '0;
                  w_resident_next = 1'b1;
                  state_next      = WAIT_SPACE;
               end else begin
                  beat_cnt_next = beat_cnt + RW'(1);
               end
            end else if (beat_cnt != '0) begin
               gap = 1'b1;
            end
         end
         WAIT_SPACE: begin
            if (fifo_has_space) state_next = STREAM;
         end
         STREAM: begin
            src_ready = 1'b1;
            if (src_valid) begin
               s_beat = 1'b1;
               if (beat_cnt == LAST_ROW) begin
                  beat_cnt_next = '0;
                  inc           = 1'b1;
                  state_next    = IDLE;
               end else begin
                  beat_cnt_next = beat_cnt + RW'(1);
               end
            end else if (beat_cnt != '0) begin
               gap = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign idle = (state == IDLE) && (outstanding == '0) && drained;

   // Registered array drive; data and row indices hold between beats
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         weight_en         <= 1'b0;
         input_en          <= 1'b0;
         partial_en        <= 1'b0;
         row_in_en         <= '0;
         row_ps_en         <= '0;
         array_in          <= '0;
         array_in_partials <= '0;
      end else begin
         weight_en  <= w_beat;
         input_en   <= s_beat;
         partial_en <= s_beat;
         if (w_beat || s_beat) begin
            row_in_en <= beat_cnt;
            array_in  <= src_data;
         end
         if (s_beat) begin
            row_ps_en         <= beat_cnt;
            array_in_partials <= src_ps;
         end
      end
   end

   assign dec_req   = out_en && (row_out == LAST_ROW);
   assign dec_ok    = dec_req && (outstanding != '0);
   assign underflow = dec_req && (outstanding == '0);

   // GEMMs streamed but not yet fully drained from the output FIFO
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         outstanding <= '0;
      end else if (inc && !dec_ok) begin
         outstanding <= outstanding + OW'(1);
      end else if (!inc && dec_ok) begin
         outstanding <= outstanding - OW'(1);
      end
   end

   // Output-silence counter; the error fires once, on the cycle the limit is reached
   always_comb begin
      if (out_en || (outstanding == '0)) begin
         tcnt_next = '0;
      end else if (tcnt != T_MAX) begin
         tcnt_next = tcnt + TW'(1);
      end else begin
         tcnt_next = tcnt;
      end
      t_set = (tcnt_next == T_MAX) && (tcnt != T_MAX);
      p_set = gap || underflow;
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         tcnt         <= '0;
         timeout_err  <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         tcnt         <= tcnt_next;
         timeout_err  <= t_set || (timeout_err && !err_clr);
         protocol_err <= p_set || (protocol_err && !err_clr);
      end
   end

   // One-cycle registered copy of the array output port
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         res_valid <= 1'b0;
         res_row   <= '0;
         res_data  <= '0;
         res_last  <= 1'b0;
      end else begin
         res_valid <= out_en;
         res_row   <= row_out;
         res_data  <= array_output;
         res_last  <= dec_req;
      end
   end

endmodule

// File: tb/tb_sa_gemm_sequencer.sv
// Randomized self-checking bench for sa_gemm_sequencer (N=4, DW=8, MAX_OUTSTANDING=2, TIMEOUT=50).
module tb_sa_gemm_sequencer;
   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int W    = DW * N;
   localparam int RW   = 2;
   localparam int OW   = 2;
   localparam int MAXO = 2;
   localparam int TMO  = 50;

   logic          clk = 1'b0;
   logic          nRST;
   logic          cmd_valid, cmd_ready, cmd_reuse_w;
   logic          src_valid, src_ready;
   logic [W-1:0]  src_data, src_ps;
   logic          weight_en, input_en, partial_en;
   logic [RW-1:0] row_in_en, row_ps_en;
   logic [W-1:0]  array_in, array_in_partials;
   logic          fifo_has_space, drained, out_en;
   logic [RW-1:0] row_out;
   logic [W-1:0]  array_output;
   logic          res_valid;
   logic [RW-1:0] res_row;
   logic [W-1:0]  res_data;
   logic          res_last, idle;
   logic [OW-1:0] outstanding;
   logic          timeout_err, protocol_err, err_clr;

   sa_gemm_sequencer #(.N(N), .DW(DW), .MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)) dut (
      .clk(clk), .nRST(nRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_reuse_w(cmd_reuse_w), .src_valid(src_valid), .src_ready(src_ready),
      .src_data(src_data), .src_ps(src_ps), .weight_en(weight_en), .input_en(input_en),
      .partial_en(partial_en), .row_in_en(row_in_en), .row_ps_en(row_ps_en),
      .array_in(array_in), .array_in_partials(array_in_partials),
      .fifo_has_space(fifo_has_space), .drained(drained), .out_en(out_en),
      .row_out(row_out), .array_output(array_output), .res_valid(res_valid),
      .res_row(res_row), .res_data(res_data), .res_last(res_last), .idle(idle),
      .outstanding(outstanding), .timeout_err(timeout_err), .protocol_err(protocol_err),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   typedef logic [W-1:0] rows_t [N];
   typedef struct {
      int            c;
      logic [RW-1:0] row;
      logic [RW-1:0] prow;
      logic [W-1:0]  d;
      logic [W-1:0]  p;
      logic          flag;
   } ev_t;

   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;
   int  last_beat_cyc = 0;
   bit  resident = 1'b0;
   int  m_out = 0;
   ev_t wq[$], sq[$], rq[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Observed array and result traffic, sampled mid-cycle
   always @(negedge clk) begin
      if (nRST) begin
         if (weight_en) wq.push_back('{cyc, row_in_en, '0, array_in, '0, 1'b0});
         if (input_en || partial_en)
            sq.push_back('{cyc, row_in_en, row_ps_en, array_in, array_in_partials, input_en && partial_en});
         if (res_valid) rq.push_back('{cyc, res_row, '0, res_data, '0, res_last});
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      resident = 1'b0;
      m_out = 0;
      tick();
   endtask

   task automatic send_cmd(input bit reuse, output int acc);
      int n = 0;
      cmd_valid   = 1'b1;
      cmd_reuse_w = reuse;
      while (!cmd_ready && n < 200) begin tick(); n++; end
      if (!cmd_ready) begin
         total++; bad++;
         $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
      end
      acc = cyc;
      tick();
      cmd_valid   = 1'b0;
      cmd_reuse_w = 1'b0;
   endtask

   task automatic send_rows(input rows_t d, input rows_t p, input int gap_at, input bit coincide);
      for (int k = 0; k < N; k++) begin
         int n = 0;
         if (k == gap_at) begin src_valid = 1'b0; tick(); end
         src_valid = 1'b1;
         src_data  = d[k];
         src_ps    = p[k];
         while (!src_ready && n < 200) begin tick(); n++; end
         if (!src_ready) begin
            total++; bad++;
            $display("FAIL src_ready_wait: src_ready=%0b at beat %0d, required 1", src_ready, k);
         end
         if (coincide && k == N - 1) begin
            out_en       = 1'b1;
            row_out      = RW'(N - 1);
            array_output = $urandom;
         end
         tick();
         out_en = 1'b0;
      end
      last_beat_cyc = cyc;
      src_valid = 1'b0;
   endtask

   // One GEMM end-to-end, with array traffic compared against the expected rows and timing
   task automatic run_gemm(input bit reuse, input int space_delay, input int gap_at, input bit coincide);
      rows_t wd, id, pd, zero;
      int acc, r, lastw, first_s, exp_c;
      bit exp_load;
      for (int k = 0; k < N; k++) begin
         wd[k] = $urandom; id[k] = $urandom; pd[k] = $urandom; zero[k] = '0;
      end
      wq.delete(); sq.delete();
      fifo_has_space = (space_delay == 0);
      send_cmd(reuse, acc);
      exp_load = !(reuse && resident);
      if (exp_load) begin
         resident = 1'b0;
         send_rows(wd, zero, gap_at, 1'b0);
         resident = 1'b1;
      end
      r = -1;
      for (int i = 0; i < space_delay; i++) begin
         total++;
         if (src_ready !== 1'b0 || input_en !== 1'b0 || partial_en !== 1'b0) begin
            bad++;
            $display("FAIL wait_space_quiet: src_ready=%0b input_en=%0b partial_en=%0b, required 0",
                     src_ready, input_en, partial_en);
         end
         tick();
      end
      if (space_delay > 0) begin fifo_has_space = 1'b1; r = cyc; end
      send_rows(id, pd, -1, coincide);
      tick();

      total++;
      if (wq.size() != (exp_load ? N : 0)) begin
         bad++;
         $display("FAIL weight_count: got %0d weight_en cycles, required %0d", wq.size(), exp_load ? N : 0);
      end
      lastw = acc + 2 + N - 1 + ((gap_at >= 0) ? 1 : 0);
      for (int k = 0; k < N && k < wq.size(); k++) begin
         exp_c = acc + 2 + k + ((gap_at >= 0 && k >= gap_at) ? 1 : 0);
         total++;
         if (wq[k].c !== exp_c || wq[k].row !== RW'(k) || wq[k].d !== wd[k]) begin
            bad++;
            $display("FAIL weight_beat%0d: cyc=%0d row=%0d data=%h, required cyc=%0d row=%0d data=%h",
                     k, wq[k].c, wq[k].row, wq[k].d, exp_c, k, wd[k]);
         end
      end
      if (r >= 0)        first_s = r + 2;
      else if (exp_load) first_s = lastw + 2;
      else               first_s = acc + 3;
      total++;
      if (sq.size() != N) begin
         bad++;
         $display("FAIL stream_count: got %0d input_en cycles, required %0d", sq.size(), N);
      end
      for (int k = 0; k < N && k < sq.size(); k++) begin
         total++;
         if (sq[k].c !== first_s + k || sq[k].row !== RW'(k) || sq[k].prow !== RW'(k) ||
             sq[k].d !== id[k] || sq[k].p !== pd[k] || sq[k].flag !== 1'b1) begin
            bad++;
            $display("FAIL stream_beat%0d: cyc=%0d rows=%0d/%0d data=%h ps=%h both=%0b, required cyc=%0d rows=%0d data=%h ps=%h both=1",
                     k, sq[k].c, sq[k].row, sq[k].prow, sq[k].d, sq[k].p, sq[k].flag,
                     first_s + k, k, id[k], pd[k]);
         end
      end
      if (!coincide) m_out++;
      total++;
      if (outstanding !== OW'(m_out)) begin
         bad++;
         $display("FAIL outstanding_after_gemm: got %0d, required %0d", outstanding, m_out);
      end
   endtask

   task automatic drain();
      rows_t od;
      int c0;
      rq.delete();
      c0 = cyc;
      for (int k = 0; k < N; k++) begin
         od[k]        = $urandom;
         out_en       = 1'b1;
         row_out      = RW'(k);
         array_output = od[k];
         tick();
      end
      out_en = 1'b0;
      tick();
      if (m_out > 0) m_out--;
      total++;
      if (rq.size() != N) begin
         bad++;
         $display("FAIL res_count: got %0d res_valid cycles, required %0d", rq.size(), N);
      end
      for (int k = 0; k < N && k < rq.size(); k++) begin
         total++;
         if (rq[k].c !== c0 + k + 1 || rq[k].row !== RW'(k) || rq[k].d !== od[k] ||
             rq[k].flag !== (k == N - 1)) begin
            bad++;
            $display("FAIL res_row%0d: cyc=%0d row=%0d data=%h last=%0b, required cyc=%0d row=%0d data=%h last=%0b",
                     k, rq[k].c, rq[k].row, rq[k].d, rq[k].flag, c0 + k + 1, k, od[k], k == N - 1);
         end
      end
      total++;
      if (outstanding !== OW'(m_out)) begin
         bad++;
         $display("FAIL outstanding_after_drain: got %0d, required %0d", outstanding, m_out);
      end
   endtask

   task automatic test_reset();
      nRST = 1'b0; cmd_valid = 0; cmd_reuse_w = 0; src_valid = 0; src_data = '0; src_ps = '0;
      fifo_has_space = 1; drained = 1; out_en = 0; row_out = '0; array_output = '0; err_clr = 0;
      #1;
      total++;
      if (cmd_ready !== 1'b1 || idle !== 1'b1 || outstanding !== '0) begin
         bad++;
         $display("FAIL reset_ready_idle: cmd_ready=%0b idle=%0b outstanding=%0d, required 1 1 0",
                  cmd_ready, idle, outstanding);
      end
      total++;
      if ({weight_en, input_en, partial_en, src_ready, res_valid, res_last, timeout_err, protocol_err} !== 8'h00) begin
         bad++;
         $display("FAIL reset_zero_outputs: got %b, required 00000000",
                  {weight_en, input_en, partial_en, src_ready, res_valid, res_last, timeout_err, protocol_err});
      end
      drained = 1'b0;
      #1;
      total++;
      if (idle !== 1'b0) begin bad++; $display("FAIL reset_idle_drained: idle=%0b, required 0", idle); end
      drained = 1'b1;
      repeat (2) tick();
      nRST = 1'b1;
      tick();
      total++;
      if (cmd_ready !== 1'b1 || idle !== 1'b1) begin
         bad++;
         $display("FAIL post_reset: cmd_ready=%0b idle=%0b, required 1 1", cmd_ready, idle);
      end
   endtask

   task automatic test_basic();
      run_gemm(1'b0, 0, -1, 1'b0);
      drain();
      total++;
      if (idle !== 1'b1) begin bad++; $display("FAIL basic_idle: idle=%0b, required 1", idle); end
   endtask

   task automatic test_reuse();
      run_gemm(1'b1, 0, -1, 1'b0);
      drain();
      do_reset();
      run_gemm(1'b1, 0, -1, 1'b0);
      drain();
   endtask

   task automatic test_wait_space();
      run_gemm(1'b1, 10, -1, 1'b0);
      drain();
      run_gemm(1'b0, 3, -1, 1'b0);
      drain();
   endtask

   task automatic test_outstanding();
      run_gemm(1'b1, 0, -1, 1'b0);
      run_gemm(1'b1, 0, -1, 1'b0);
      cmd_valid = 1'b1; cmd_reuse_w = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (cmd_ready !== 1'b0 || src_ready !== 1'b0 || outstanding !== OW'(MAXO)) begin
            bad++;
            $display("FAIL full_blocks_cmd: cmd_ready=%0b src_ready=%0b outstanding=%0d, required 0 0 %0d",
                     cmd_ready, src_ready, outstanding, MAXO);
         end
         tick();
      end
      cmd_valid = 1'b0; cmd_reuse_w = 1'b0;
      drain();
      run_gemm(1'b1, 0, -1, 1'b1);
      drain();
   endtask

   task automatic test_protocol();
      clear_err();
      total++;
      if (protocol_err !== 1'b0) begin bad++; $display("FAIL proto_pre: protocol_err=%0b, required 0", protocol_err); end
      run_gemm(1'b0, 0, 2, 1'b0);
      total++;
      if (protocol_err !== 1'b1) begin bad++; $display("FAIL proto_gap: protocol_err=%0b, required 1", protocol_err); end
      clear_err();
      total++;
      if (protocol_err !== 1'b0) begin bad++; $display("FAIL proto_clear: protocol_err=%0b, required 0", protocol_err); end
      drain();
      out_en = 1'b1; row_out = RW'(N - 1); err_clr = 1'b1;
      tick();
      out_en = 1'b0; err_clr = 1'b0;
      total++;
      if (protocol_err !== 1'b1 || outstanding !== '0) begin
         bad++;
         $display("FAIL proto_underflow: protocol_err=%0b outstanding=%0d, required 1 0", protocol_err, outstanding);
      end
      clear_err();
   endtask

   task automatic test_timeout();
      int acc;
      clear_err();
      run_gemm(1'b1, 0, -1, 1'b0);
      while (cyc < last_beat_cyc + TMO - 1) tick();
      total++;
      if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_early: timeout_err=%0b at %0d, required 0", timeout_err, TMO - 1); end
      tick();
      total++;
      if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_set: timeout_err=%0b at %0d, required 1", timeout_err, TMO); end
      clear_err();
      repeat (3) tick();
      total++;
      if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clear: timeout_err=%0b, required 0", timeout_err); end
      send_cmd(1'b1, acc);
      tick();
      src_valid = 1'b1; src_data = $urandom; src_ps = $urandom;
      repeat (2) tick();
      total++;
      if (input_en !== 1'b1) begin bad++; $display("FAIL mid_stream: input_en=%0b, required 1", input_en); end
      #2 nRST = 1'b0;
      #1;
      total++;
      if ({weight_en, input_en, partial_en, src_ready, res_valid, timeout_err, protocol_err} !== 7'h00 ||
          cmd_ready !== 1'b1 || outstanding !== '0 || idle !== drained || array_in !== '0 || row_in_en !== '0) begin
         bad++;
         $display("FAIL async_reset: en/rdy/err=%b cmd_ready=%0b outstanding=%0d idle=%0b array_in=%h, required 0000000 1 0 1 0",
                  {weight_en, input_en, partial_en, src_ready, res_valid, timeout_err, protocol_err},
                  cmd_ready, outstanding, idle, array_in);
      end
      src_valid = 1'b0;
      resident = 1'b0;
      m_out = 0;
      tick();
      nRST = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         run_gemm(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1, 1'b0);
         if (m_out == MAXO || $urandom_range(0, 1) == 1) drain();
      end
      while (m_out > 0) drain();
      total++;
      if (idle !== 1'b1) begin bad++; $display("FAIL random_final_idle: idle=%0b, required 1", idle); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reuse();
      test_wait_space();
      test_outstanding();
      test_protocol();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
